// File: rtl/accel_argmax.sv
// accel_argmax: streaming arg-max over an fp32 vector using IEEE-754 total ordering.
// Accepts one word per cycle while accumulating. Each vector produces a two-beat result:
// the maximum value, then an index word {err, 0..., index}.
//
// Ports:
//   clk                 system clock, rising edge
//   rst                 synchronous active-low reset
//   INPUT_AXIS_TDATA    fp32 vector element
//   INPUT_AXIS_TLAST    final element of the vector
//   INPUT_AXIS_TVALID   upstream word valid
//   INPUT_AXIS_TREADY   block accepts a word (accumulate state only)
//   OUTPUT_AXIS_TDATA   beat 0: max value bits; beat 1: index word
//   OUTPUT_AXIS_TLAST   high on beat 1 only
//   OUTPUT_AXIS_TVALID  result beat valid
//   OUTPUT_AXIS_TREADY  downstream accepts a beat
module accel_argmax #(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = $clog2(N)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] INPUT_AXIS_TDATA,
   input  logic        INPUT_AXIS_TLAST,
   input  logic        INPUT_AXIS_TVALID,
   output logic        INPUT_AXIS_TREADY,
   output logic [31:0] OUTPUT_AXIS_TDATA,
   output logic        OUTPUT_AXIS_TLAST,
   output logic        OUTPUT_AXIS_TVALID,
   input  logic        OUTPUT_AXIS_TREADY
);

   typedef enum logic [1:0] {
      StAcc,
      StSendVal,
      StSendIdx
   } state_t;

   localparam logic [IDX_W-1:0] LastCnt = IDX_W'(N - 1);

   state_t           state;
   logic [IDX_W-1:0] count;
   logic [IDX_W-1:0] best_idx;
   logic [31:0]      best_key;
   logic [31:0]      best_val;
   logic             err;

   logic             in_hs;
   logic             out_hs;
   logic             take;
   logic             is_nth;
   logic             vec_end;
   logic [31:0]      in_key;
   logic [31:0]      nxt_val;
   logic [IDX_W-1:0] nxt_idx;
   logic [31:0]      idx_word;

   // Maps fp32 bits onto an unsigned key whose order matches IEEE-754 total order:
   // positives get the top bit set, negatives are inverted so larger magnitude sorts lower.
   function automatic logic [31:0] order_key(input logic [31:0] v);
      return v[31] ? ~v : {1'b1, v[30:0]};
   endfunction

   always_comb begin
      in_key   = order_key(INPUT_AXIS_TDATA);
      in_hs    = (state == StAcc) && INPUT_AXIS_TVALID && INPUT_AXIS_TREADY;
      out_hs   = OUTPUT_AXIS_TVALID && OUTPUT_AXIS_TREADY;
      // First word always loads; afterwards strictly greater only, so the first tie wins.
      take     = (count == '0) || (in_key > best_key);
      is_nth   = (count == LastCnt);
      vec_end  = INPUT_AXIS_TLAST || is_nth;
      nxt_val  = take ? INPUT_AXIS_TDATA : best_val;
      nxt_idx  = take ? count : best_idx;
      idx_word = '0;
      idx_word[IDX_W-1:0] = best_idx;
      idx_word[31]        = err;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state              <= StAcc;
         count              <= '0;
         best_idx           <= '0;
         best_key           <= '0;
         best_val           <= '0;
         err                <= 1'b0;
         INPUT_AXIS_TREADY  <= 1'b0;
         OUTPUT_AXIS_TDATA  <= '0;
         OUTPUT_AXIS_TLAST  <= 1'b0;
         OUTPUT_AXIS_TVALID <= 1'b0;
      end else begin
         unique case (state)
            StAcc: begin
               INPUT_AXIS_TREADY <= 1'b1;
               if (in_hs) begin
                  if (take) begin
                     best_key <= in_key;
                     best_val <= INPUT_AXIS_TDATA;
                     best_idx <= count;
                  end
                  if (vec_end) begin
                     // Length error whenever TLAST and the Nth word do not coincide.
                     err                <= (INPUT_AXIS_TLAST != is_nth);
                     count              <= '0;
                     state              <= StSendVal;
                     INPUT_AXIS_TREADY  <= 1'b0;
                     OUTPUT_AXIS_TVALID <= 1'b1;
                     OUTPUT_AXIS_TLAST  <= 1'b0;
                     OUTPUT_AXIS_TDATA  <= nxt_val;
                  end else begin
                     count <= count + IDX_W'(1);
                  end
               end
            end
            StSendVal: begin
               if (out_hs) begin
                  state             <= StSendIdx;
                  OUTPUT_AXIS_TDATA <= idx_word;
                  OUTPUT_AXIS_TLAST <= 1'b1;
               end
            end
            StSendIdx: begin
               if (out_hs) begin
                  state              <= StAcc;
                  count              <= '0;
                  err                <= 1'b0;
                  OUTPUT_AXIS_TVALID <= 1'b0;
                  OUTPUT_AXIS_TLAST  <= 1'b0;
                  OUTPUT_AXIS_TDATA  <= '0;
                  // Ready again on the very next cycle keeps vector overhead at 2 cycles.
                  INPUT_AXIS_TREADY  <= 1'b1;
               end
            end
            default: state <= StAcc;
         endcase
      end
   end

   // nxt_idx documents the load decision; best_idx is updated from count directly.
   logic unused_nxt;
   assign unused_nxt = ^nxt_idx;

endmodule

// File: doc/accel_argmax.md
# accel_argmax

Streaming arg-max stage directly downstream of `accel_dot`. It consumes the fp32 result vector produced by the dot-product engine over AXI4-Stream and finds the largest element using IEEE-754 single-precision ordering. For each vector it emits a two-beat AXI4-Stream result: the maximum value, then its index. It accepts one input word per cycle so it never throttles the dot engine while accumulating.

## Interface
- `N`, default 4: nominal vector length, i.e. the `accel_dot` output length. Must be ≥ 2.
- `IDX_W`, default `$clog2(N)`: width of the internal index counter.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-low reset: the block is in reset while `rst` = 0, sampled on the rising edge of `clk`.
- `INPUT_AXIS_TDATA`  in  32  fp32 vector element.
- `INPUT_AXIS_TLAST`  in  1  final element of the vector.
- `INPUT_AXIS_TVALID`  in  1  upstream word valid.
- `INPUT_AXIS_TREADY`  out  1  block accepts a word.
- `OUTPUT_AXIS_TDATA`  out  32  beat 0 is the max value (fp32 bits); beat 1 is the index word.
- `OUTPUT_AXIS_TLAST`  out  1  high on beat 1 only.
- `OUTPUT_AXIS_TVALID`  out  1  result beat valid.
- `OUTPUT_AXIS_TREADY`  in  1  downstream accepts a beat.

## Operation
- **FSM states:** ACC, SEND_VAL, SEND_IDX.
- **Reset state:** reset forces ACC, clears the element count, the best key/value/index registers and the error flag, and drives all outputs to 0.
- **ACC:**
  - `INPUT_AXIS_TREADY` = 1.
  - On each handshake (TVALID & TREADY), compare the word against the running best.
  - The first word of a vector always loads the best registers.
  - The count increments per accepted word.
- **Ordering key:** if bit31 = 0, key = {1'b1, bits[30:0]}; if bit31 = 1, key = ~bits. Keys compare as unsigned 32-bit values.
  - Consequence: −0 < +0; +NaN ranks above +Inf; −NaN ranks below −Inf. No NaN special-casing.
- **Ties:** replace only if the new key is strictly greater, so the first occurrence wins.
- **End of vector:** accepting a word with TLAST = 1, or accepting the Nth word, whichever comes first.
  - The FSM then moves to SEND_VAL.
  - The error flag is latched when TLAST position ≠ N, i.e. TLAST early, or the Nth word arrives with TLAST = 0.
  - Words arriving after a forced end-at-N begin a new vector.
- **SEND_VAL:**
  - `OUTPUT_AXIS_TVALID` = 1, TDATA = best value bits, TLAST = 0.
  - On handshake, go to SEND_IDX.
- **SEND_IDX:**
  - TVALID = 1, TLAST = 1.
  - TDATA[IDX_W-1:0] = best index; TDATA[31] = error flag; other bits 0.
  - On handshake: clear the count and the error flag, then return to ACC.
- `INPUT_AXIS_TREADY` = 0 in SEND_VAL and SEND_IDX.

## Timing
- All outputs are registered, or decoded from the registered state only. No combinational path from any input to any output.
- **Throughput:** one input word per cycle in ACC.
- **Latency:** OUTPUT TVALID rises on the cycle after the final input handshake edge. With TREADY held high, the two result beats complete in 2 cycles. Vector-to-vector overhead is 2 cycles.
- **Backpressure:** while TVALID = 1 and TREADY = 0, TDATA and TLAST stay stable; TVALID never drops before its handshake.
- **Simultaneous events:** INPUT TVALID asserted during SEND_* is ignored; no word is lost because TREADY = 0.
- **Reset mid-vector or mid-output:** the partial vector and any pending result are discarded. Outputs read 0 on the first cycle after reset is sampled low. TREADY returns to 1 on the first cycle after `rst` is sampled high.

## Test plan
- **Nominal vector, N = 4:** inputs 3F800000, 40000000, 3F000000, C0400000 (TLAST on word 3) → beat 0 = 40000000; beat 1 = 00000001 with TLAST. TVALID rises 1 cycle after the last input handshake.
- **All negative:** C0400000, BF800000, C0000000, C0800000 → 40000000 is not emitted; beat 0 = BF800000, beat 1 = 00000001.
- **Tie and signed zero:** 40000000, 40000000, 80000000, 00000000 → index 0. Separately, vector 80000000, 00000000, 80000000, 80000000 → beat 0 = 00000000, index 1.
- **Length error:** TLAST on word 2 of (3F800000, 40400000) → beat 0 = 40400000, beat 1 = 80000001. Also 4 words with no TLAST → beat 1 has bit31 set and the block accepts the next vector.
- **Output backpressure:** hold OUTPUT TREADY = 0 for 5 cycles after TVALID rises → TDATA/TLAST stable, INPUT TREADY = 0 throughout. Both beats are delivered once TREADY = 1.
- **Reset mid-vector:** drop `rst` after 2 words → OUTPUT TVALID = 0. A following full vector 3F800000, 3F000000, 40800000, 3F800000 yields 40800000 / index 2, unaffected by the pre-reset words.
